// File: rtl/mac_rx_frame_chk.sv
// MII/GMII receive front end: preamble/SFD detect, byte assembly, CRC-32 check,
// MAX_LEN truncation and a one-word status per frame for the FIFO writer.
module mac_rx_frame_chk #(
  parameter int DW      = 4,
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          rx_dv,
  input  logic          rx_er,
  input  logic [DW-1:0] rx_d,
  output logic          out_valid,
  output logic [7:0]    out_data,
  output logic          out_sop,
  output logic          out_eop,
  output logic          stat_valid,
  output logic [11:0]   stat_len,
  output logic          stat_crc_err,
  output logic          stat_len_err,
  output logic          stat_align_err,
  output logic          stat_rx_err
);

  localparam logic [31:0] POLY    = 32'hEDB88320;
  localparam logic [31:0] RESIDUE = 32'hDEBB20E3;
  localparam logic [7:0]  PRE_V   = 8'h55;
  localparam logic [7:0]  SFD_V   = (DW == 4) ? 8'h0D : 8'hD5;
  localparam logic [11:0] MIN_L   = 12'(MIN_LEN);
  localparam logic [11:0] MAX_L   = 12'(MAX_LEN);

  typedef enum logic [1:0] {S_DROP, S_IDLE, S_PRE, S_DATA} state_t;

  state_t      r_state, w_next;
  logic        w_enter_data, w_in_data, w_end;
  logic        w_is_pre, w_is_sfd;
  logic        w_byte_done, w_dangle;
  logic [7:0]  w_byte;
  logic        r_pre_seen;
  logic [31:0] r_crc;
  logic [11:0] r_cnt;
  logic [7:0]  r_hold;
  logic        r_hold_vld, r_hold_sop, r_rx_err;

  function automatic logic [31:0] f_crc(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ POLY) : (r >> 1);
    return r;
  endfunction

  assign w_is_pre = (rx_d == PRE_V[DW-1:0]);
  assign w_is_sfd = (rx_d == SFD_V[DW-1:0]);

  always_ff @(posedge clk or posedge reset)
    if (reset) r_state <= S_DROP;
    else       r_state <= w_next;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_DROP: if (!rx_dv) w_next = S_IDLE;
      S_IDLE: if (rx_dv)  w_next = S_PRE;
      S_PRE: begin
        if (!rx_dv)                      w_next = S_IDLE;
        else if (w_is_sfd && r_pre_seen) w_next = S_DATA;
        else if (!w_is_pre)              w_next = S_DROP;
      end
      S_DATA: if (!rx_dv) w_next = S_IDLE;
      default: w_next = S_DROP;
    endcase
  end

  always_comb begin
    w_enter_data = (r_state == S_PRE) && (w_next == S_DATA);
    w_in_data    = (r_state == S_DATA) && rx_dv;
    w_end        = (r_state == S_DATA) && !rx_dv;
  end

  // MII: low nibble arrives first; a byte completes on the high nibble.
  if (DW == 4) begin : g_mii
    logic       r_half;
    logic [3:0] r_lo;
    always_ff @(posedge clk or posedge reset)
      if (reset) begin
        r_half <= 1'b0;
        r_lo   <= 4'h0;
      end else if (w_enter_data) begin
        r_half <= 1'b0;
      end else if (w_in_data) begin
        r_half <= ~r_half;
        if (!r_half) r_lo <= rx_d;
      end
    assign w_byte_done = w_in_data & r_half;
    assign w_byte      = {rx_d, r_lo};
    assign w_dangle    = r_half;
  end else begin : g_gmii
    assign w_byte_done = w_in_data;
    assign w_byte      = rx_d;
    assign w_dangle    = 1'b0;
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_pre_seen     <= 1'b0;
      r_crc          <= 32'hFFFFFFFF;
      r_cnt          <= 12'd0;
      r_hold         <= 8'h0;
      r_hold_vld     <= 1'b0;
      r_hold_sop     <= 1'b0;
      r_rx_err       <= 1'b0;
      out_valid      <= 1'b0;
      out_data       <= 8'h0;
      out_sop        <= 1'b0;
      out_eop        <= 1'b0;
      stat_valid     <= 1'b0;
      stat_len       <= 12'd0;
      stat_crc_err   <= 1'b0;
      stat_len_err   <= 1'b0;
      stat_align_err <= 1'b0;
      stat_rx_err    <= 1'b0;
    end else begin
      out_valid  <= 1'b0;
      out_sop    <= 1'b0;
      out_eop    <= 1'b0;
      stat_valid <= 1'b0;
      if (r_state == S_IDLE)               r_pre_seen <= w_is_pre;
      else if (r_state == S_PRE && w_is_pre) r_pre_seen <= 1'b1;
      if (w_enter_data) begin
        r_crc      <= 32'hFFFFFFFF;
        r_cnt      <= 12'd0;
        r_hold_vld <= 1'b0;
        r_rx_err   <= 1'b0;
      end
      if (w_in_data && rx_er) r_rx_err <= 1'b1;
      if (w_byte_done) begin
        r_crc <= f_crc(r_crc, w_byte);
        if (r_cnt != 12'hFFF) r_cnt <= r_cnt + 12'd1;
        // Past MAX_LEN the held byte is frozen so it can leave as the eop beat.
        if (r_cnt < MAX_L) begin
          if (r_hold_vld) begin
            out_valid <= 1'b1;
            out_data  <= r_hold;
            out_sop   <= r_hold_sop;
          end
          r_hold     <= w_byte;
          r_hold_vld <= 1'b1;
          r_hold_sop <= (r_cnt == 12'd0);
        end
      end
      if (w_end) begin
        out_valid      <= r_hold_vld;
        out_data       <= r_hold;
        out_sop        <= r_hold_vld & r_hold_sop;
        out_eop        <= r_hold_vld;
        r_hold_vld     <= 1'b0;
        stat_valid     <= 1'b1;
        stat_len       <= r_cnt;
        stat_crc_err   <= (r_crc != RESIDUE);
        stat_len_err   <= (r_cnt < MIN_L) || (r_cnt > MAX_L);
        stat_align_err <= w_dangle;
        stat_rx_err    <= r_rx_err | rx_er;
      end
    end

endmodule

// File: tb/tb_mac_rx_frame_chk.sv
// Scoreboard bench for mac_rx_frame_chk: one MII and one GMII instance, directed
// frames, expected beats/status queued at stimulus time and popped by a monitor.
module tb_mac_rx_frame_chk;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       dv4, er4, dv8, er8;
  logic [3:0] d4;
  logic [7:0] d8;

  logic       v4, sop4, eop4, sv4, ce4, le4, ae4, re4;
  logic [7:0] od4;
  logic [11:0] sl4;
  logic       v8, sop8, eop8, sv8, ce8, le8, ae8, re8;
  logic [7:0] od8;
  logic [11:0] sl8;

  mac_rx_frame_chk #(.DW(4)) u_dut4 (
    .clk(clk), .reset(reset), .rx_dv(dv4), .rx_er(er4), .rx_d(d4),
    .out_valid(v4), .out_data(od4), .out_sop(sop4), .out_eop(eop4),
    .stat_valid(sv4), .stat_len(sl4), .stat_crc_err(ce4), .stat_len_err(le4),
    .stat_align_err(ae4), .stat_rx_err(re4));

  mac_rx_frame_chk #(.DW(8)) u_dut8 (
    .clk(clk), .reset(reset), .rx_dv(dv8), .rx_er(er8), .rx_d(d8),
    .out_valid(v8), .out_data(od8), .out_sop(sop8), .out_eop(eop8),
    .stat_valid(sv8), .stat_len(sl8), .stat_crc_err(ce8), .stat_len_err(le8),
    .stat_align_err(ae8), .stat_rx_err(re8));

  // beat = {data, sop, eop}; status = {len, crc, len_err, align, rx_err, with_eop}
  logic [9:0]  q4[$], q8[$];
  logic [16:0] s4[$], s8[$];
  logic [7:0]  frm[$];
  int n_vec = 0, n_err = 0;
  logic chk_rst = 1'b0, chk_end = 1'b0, end_done = 1'b0;
  logic [9:0]  b;
  logic [16:0] s;

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (chk_rst) begin
      cmp("reset dut4", {v4, od4, sop4, eop4, sv4, sl4, ce4, le4, ae4, re4}, 0);
      cmp("reset dut8", {v8, od8, sop8, eop8, sv8, sl8, ce8, le8, ae8, re8}, 0);
    end else if (!reset) begin
      if (v4) begin
        if (q4.size() == 0) cmp("dut4 unexpected beat", {1'b1, od4, sop4, eop4}, 0);
        else begin b = q4.pop_front(); cmp("dut4 beat", {od4, sop4, eop4}, b); end
      end
      if (sv4) begin
        if (s4.size() == 0) cmp("dut4 unexpected status", {1'b1, sl4}, 0);
        else begin s = s4.pop_front(); cmp("dut4 status", {sl4, ce4, le4, ae4, re4, v4 & eop4}, s); end
      end
      if (v8) begin
        if (q8.size() == 0) cmp("dut8 unexpected beat", {1'b1, od8, sop8, eop8}, 0);
        else begin b = q8.pop_front(); cmp("dut8 beat", {od8, sop8, eop8}, b); end
      end
      if (sv8) begin
        if (s8.size() == 0) cmp("dut8 unexpected status", {1'b1, sl8}, 0);
        else begin s = s8.pop_front(); cmp("dut8 status", {sl8, ce8, le8, ae8, re8, v8 & eop8}, s); end
      end
      if (chk_end && !end_done) begin
        cmp("queues drained", q4.size() + q8.size() + s4.size() + s8.size(), 0);
        end_done = 1'b1;
      end
    end
  end

  // DA f0.., SA e0.., type 0800, payload ramp, FCS (optionally inverted).
  task automatic build(input int n, input bit bad);
    logic [31:0] c;
    frm.delete();
    for (int i = 0; i < 6; i++) frm.push_back(8'hF0 + 8'(i));
    for (int i = 0; i < 6; i++) frm.push_back(8'hE0 + 8'(i));
    frm.push_back(8'h08);
    frm.push_back(8'h00);
    for (int i = 14; i < n - 4; i++) frm.push_back(8'(i));
    c = 32'hFFFFFFFF;
    foreach (frm[i]) c = crc_upd(c, frm[i]);
    c = ~c;
    if (bad) c = ~c;
    for (int i = 0; i < 4; i++) frm.push_back(8'(c >> (8 * i)));
  endtask

  task automatic exp_frame(input bit is8, input bit crcbad, input bit align, input bit rxerr);
    int n, fwd;
    logic [16:0] st;
    n   = frm.size();
    fwd = (n > 1518) ? 1518 : n;
    for (int i = 0; i < fwd; i++) begin
      if (is8) q8.push_back({frm[i], 1'(i == 0), 1'(i == fwd - 1)});
      else     q4.push_back({frm[i], 1'(i == 0), 1'(i == fwd - 1)});
    end
    st = {12'((n > 4095) ? 4095 : n), crcbad, 1'((n < 64) || (n > 1518)), align, rxerr, 1'(fwd > 0)};
    if (is8) s8.push_back(st); else s4.push_back(st);
  endtask

  task automatic cyc4(input logic dv, input logic er, input logic [3:0] d);
    dv4 = dv; er4 = er; d4 = d;
    @(posedge clk); #1;
  endtask

  task automatic cyc8(input logic dv, input logic er, input logic [7:0] d);
    dv8 = dv; er8 = er; d8 = d;
    @(posedge clk); #1;
  endtask

  task automatic send4(input int er_at, input bit odd);
    logic [7:0] x;
    for (int i = 0; i < 15; i++) cyc4(1'b1, 1'b0, 4'h5);
    cyc4(1'b1, 1'b0, 4'hD);
    for (int i = 0; i < frm.size(); i++) begin
      x = frm[i];
      cyc4(1'b1, 1'(i == er_at), x[3:0]);
      cyc4(1'b1, 1'b0, x[7:4]);
    end
    if (odd) cyc4(1'b1, 1'b0, 4'h3);
    cyc4(1'b0, 1'b0, 4'h0);
  endtask

  task automatic send8(input bit badpre);
    for (int i = 0; i < 7; i++) cyc8(1'b1, 1'b0, (badpre && i == 3) ? 8'h12 : 8'h55);
    cyc8(1'b1, 1'b0, 8'hD5);
    foreach (frm[i]) cyc8(1'b1, 1'b0, frm[i]);
    cyc8(1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    reset = 1'b1; chk_rst = 1'b1;
    dv4 = 0; er4 = 0; d4 = 0; dv8 = 0; er8 = 0; d8 = 0;
    repeat (3) @(posedge clk);
    #1 chk_rst = 1'b0; reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // MII frames, back to back with a single idle cycle between them
    build(100, 0);  exp_frame(0, 0, 0, 0); send4(-1, 0);
    build(100, 1);  exp_frame(0, 1, 0, 0); send4(-1, 0);
    build(59, 0);   exp_frame(0, 0, 0, 0); send4(-1, 0);
    build(1519, 1); exp_frame(0, 1, 0, 0); send4(-1, 0);
    build(64, 0);   exp_frame(0, 0, 1, 1); send4(30, 1);
    repeat (3) cyc4(1'b0, 1'b0, 4'h0);
    // reset lands one byte into a frame while rx_dv stays high
    build(64, 0);
    for (int i = 0; i < 15; i++) cyc4(1'b1, 1'b0, 4'h5);
    cyc4(1'b1, 1'b0, 4'hD);
    cyc4(1'b1, 1'b0, 4'h0);
    cyc4(1'b1, 1'b0, 4'hF);
    reset = 1'b1; chk_rst = 1'b1;
    cyc4(1'b1, 1'b0, 4'h1);
    reset = 1'b0; chk_rst = 1'b0;
    for (int i = 0; i < 20; i++) cyc4(1'b1, 1'b0, 4'(i));
    cyc4(1'b0, 1'b0, 4'h0);
    exp_frame(0, 0, 0, 0); send4(-1, 0);
    // GMII instance
    build(64, 0); exp_frame(1, 0, 0, 0); send8(0);
    build(64, 0); send8(1);
    frm.delete(); exp_frame(1, 1, 0, 0); send8(0);
    build(80, 0); exp_frame(1, 0, 0, 0); send8(0);
    for (int i = 0; i < 200 && (q4.size() + q8.size() + s4.size() + s8.size()) != 0; i++)
      @(posedge clk);
    chk_end = 1'b1;
    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mac_rx_frame_chk.md
Name: mac_rx_frame_chk

Overview:
- Parametrised MII/GMII receive front end running in the receive clock domain.
- Detects preamble/SFD and assembles nibbles (DW=4) or bytes (DW=8) into a byte stream with sop/eop.
- Computes CRC-32 (IEEE 802.3) and checks length, alignment and rx_er.
- Emits one status word per frame for the downstream data/pointer FIFO writer.

Parameters:
- DW, 4, receive data width; 4 = MII (low nibble first), 8 = GMII.
- MIN_LEN, 64, minimum legal frame bytes, DA through FCS inclusive.
- MAX_LEN, 1518, maximum legal/forwarded frame bytes, DA through FCS inclusive.

Ports:
- clk  in  1  receive clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- rx_dv  in  1  receive data valid.
- rx_er  in  1  receive error.
- rx_d  in  DW  receive data.
- out_valid  out  1  out_data is a frame byte.
- out_data  out  8  frame byte, DA first, FCS included.
- out_sop  out  1  first byte of frame; qualified by out_valid.
- out_eop  out  1  last forwarded byte; qualified by out_valid.
- stat_valid  out  1  one-cycle status strobe.
- stat_len  out  12  received byte count, saturating at 4095.
- stat_crc_err  out  1  CRC residue mismatch.
- stat_len_err  out  1  stat_len < MIN_LEN or > MAX_LEN.
- stat_align_err  out  1  odd nibble count (DW=4 only; tied 0 for DW=8).
- stat_rx_err  out  1  rx_er seen in DATA state.

Behaviour:
- Reset:
  - All outputs 0; CRC register 0xFFFFFFFF; counters 0; state DROP.
  - A frame in progress when reset asserts is lost; no status is issued for it.
- States:
  - DROP: wait for rx_dv=0, then go to IDLE.
  - IDLE: rx_dv=1 goes to PRE.
  - PRE, DW=4: 0x5 stays; 0xD after at least one 0x5 goes to DATA; any other value goes to DROP.
  - PRE, DW=8: 0x55 stays; 0xD5 after at least one 0x55 goes to DATA; any other value goes to DROP.
  - PRE: rx_dv=0 goes to IDLE. No output and no status from PRE or DROP.
  - DATA: collect bytes; rx_dv=0 ends the frame and returns to IDLE.
- Byte assembly, DW=4: the first nibble is bits [3:0], the second is bits [7:4]. A byte completes on its second nibble.
- CRC and length:
  - Every completed byte, FCS included, is fed to a reflected CRC-32 (poly 0xEDB88320, LSB first, init 0xFFFFFFFF).
  - Every completed byte increments stat_len (saturating at 4095).
  - At end of frame, register != 0xDEBB20E3 sets stat_crc_err.
- Output timing:
  - One-byte hold buffer. Byte k is driven the cycle after byte k+1 completes.
  - The last held byte is driven with out_eop the cycle after rx_dv is sampled 0.
  - The first byte carries out_sop. A 1-byte frame has out_sop and out_eop on the same beat.
- Truncation: bytes beyond MAX_LEN are not forwarded. Byte MAX_LEN stays held and exits with out_eop at frame end. Counting and CRC continue.
- Status:
  - stat_valid pulses in the same cycle as out_eop.
  - A frame with 0 completed bytes (SFD then rx_dv=0) pulses stat_valid alone, with stat_len=0 and stat_len_err=1.
  - Status fields are held until the next stat_valid.
- Alignment: DW=4 frame ending with a dangling nibble → nibble discarded, stat_align_err=1.
- rx_er: rx_er=1 in any DATA cycle latches stat_rx_err for that frame. Forwarding continues.
- Back-to-back frames: one rx_dv=0 cycle between frames is sufficient. The eop/status of frame N may coincide with PRE of frame N+1.
- The CRC register and all counters reinit on entry to DATA.

Test Plan:
- DW=4: 7×0x55 nibble pairs + SFD, 100-byte frame, DA f0f1f2f3f4f5, SA e0e1e2e3e4e5, type 0x0800, correct FCS → 100 beats: sop on 0xF0, eop on the last FCS byte; stat_len=100, all error flags 0.
- Same frame with FCS bytes inverted → identical data stream; stat_crc_err=1, other flags 0.
- 59-byte frame with good FCS → stat_len=59, stat_len_err=1, crc_err=0.
- 1515-byte data + 4 FCS (1519 bytes) → exactly 1518 beats forwarded, eop on the 1518th; stat_len=1519, len_err=1, crc_err=1.
- DW=4 frame ending after an odd nibble (129 nibbles) → 64 bytes forwarded, stat_align_err=1; rx_er pulsed mid-frame → stat_rx_err=1.
- Reset asserted mid-frame with rx_dv held high → no output and no status until rx_dv falls; next frame received normally.
- DW=8 build: 0x55×7, 0xD5, 64-byte good frame → stat_len=64, all error flags 0.
- DW=8 build: 0x12 inside the preamble → no output, no stat_valid.
